// File: rtl/bcd_gate_controller.sv
// bcd_gate_controller: gate-time sequencer for an external N-digit BCD event counter.
// Each measurement runs in this order:
//   1. clear the counter;
//   2. open a gate of GATE_CYCLES clocks;
//   3. let the last increment settle;
//   4. latch the count and a sticky wrap flag;
//   5. offer the result to the consumer.
// Result handshake: result_valid is held high with result/result_ovf stable until a
// rising clk edge sees result_valid & result_ready; that edge completes the transfer.
// Optional build macro BCD_GATE_SATURATE_EN: the first counter wrap inside the gate
// stops counting, and the latched result reads all nines.
module bcd_gate_controller #(
    parameter int Ndigit      = 3,
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic                pulse_in,
    output logic                cnt_rst,
    output logic                cnt_en,
    input  logic [Ndigit*4-1:0] BCD,
    input  logic                overflow,
    output logic [Ndigit*4-1:0] result,
    output logic                result_ovf,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]    GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [Ndigit*4-1:0] ALL_NINES = {Ndigit{4'h9}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q;
    logic               ovf_sticky_q;
    // Holds the counter clear from reset until the first clock edge after release.
    logic               init_clr_q;
    logic               gate_last;

    assign gate_last = (timer_q == GATE_LAST);
    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE, the handshake decides CLEAR vs IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_GATE;
            S_GATE:   if (gate_last) state_d = S_SETTLE;
            S_SETTLE: state_d = S_HOLD;
            S_HOLD:   if (result_ready) state_d = continuous ? S_CLEAR : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: Moore decode of the state, except cnt_en which passes pulse_in through in GATE
    always_comb begin
        cnt_rst      = init_clr_q || (state_q == S_CLEAR);
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_HOLD);
        cnt_en       = 1'b0;
        if (state_q == S_GATE) begin
`ifdef BCD_GATE_SATURATE_EN
            cnt_en = pulse_in && !ovf_sticky_q;
`else
            cnt_en = pulse_in;
`endif
        end
    end

    // Gate timer, sticky wrap flag, power-up clear flag and result latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q      <= '0;
            ovf_sticky_q <= 1'b0;
            init_clr_q   <= 1'b1;
            result       <= '0;
            result_ovf   <= 1'b0;
        end else begin
            init_clr_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    timer_q      <= '0;
                    ovf_sticky_q <= 1'b0;
                end
                S_GATE: begin
                    timer_q <= timer_q + CNT_W'(1);
                    if (overflow) ovf_sticky_q <= 1'b1;
                end
                S_SETTLE: begin
`ifdef BCD_GATE_SATURATE_EN
                    result <= ovf_sticky_q ? ALL_NINES : BCD;
`else
                    result <= BCD;
`endif
                    result_ovf <= ovf_sticky_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_gate_controller.sv
// Bench for bcd_gate_controller.
// Two instances are used: gate lengths of 20 and 120 clocks, both with 2 BCD digits.
// A simple external BCD counter is modelled for each instance. The expected result of
// each measurement is computed from the pulses the bench drove inside the gate window.
module tb_bcd_gate_controller;

    localparam int ND  = 2;
    localparam int G0  = 20;
    localparam int G1  = 120;
    localparam int MOD = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]        start_v, cont_v, pulse_v, ready_v;
    logic [1:0]        cnt_rst_o, cnt_en_o, ovf_s, rovf_o, valid_o, busy_o;
    logic [1:0][7:0]   bcd_s, result_o;
    logic [1:0][2:0]   dbg_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] last_res [2];
    logic       last_ovf [2];

    // Clock
    always #5 clk = ~clk;

    // DUTs plus a behavioural BCD counter for each one
    for (genvar g = 0; g < 2; g++) begin : g_dut
        int cnt_val = 0;

        bcd_gate_controller #(
            .Ndigit(ND), .GATE_CYCLES(g == 0 ? G0 : G1), .CNT_W(8)
        ) dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .continuous(cont_v[g]),
            .pulse_in(pulse_v[g]), .cnt_rst(cnt_rst_o[g]), .cnt_en(cnt_en_o[g]),
            .BCD(bcd_s[g]), .overflow(ovf_s[g]), .result(result_o[g]),
            .result_ovf(rovf_o[g]), .result_valid(valid_o[g]),
            .result_ready(ready_v[g]), .busy(busy_o[g]), .state_dbg(dbg_o[g])
        );

        assign bcd_s[g] = 8'(((cnt_val / 10) % 10) * 16 + (cnt_val % 10));
        assign ovf_s[g] = cnt_en_o[g] && (cnt_val == MOD - 1);

        always @(posedge clk) begin
            if (cnt_rst_o[g])     cnt_val <= 0;
            else if (cnt_en_o[g]) cnt_val <= (cnt_val + 1) % MOD;
        end
    end

    function automatic logic [7:0] to_bcd(input int c);
        return 8'(((c / 10) % 10) * 16 + (c % 10));
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Scoreboard primitive
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk(input int k, input string tag, input bit e_rst, input bit e_en,
                       input bit e_valid, input bit e_busy);
        check({tag, "_cnt_rst"}, 32'(cnt_rst_o[k]), 32'(e_rst));
        check({tag, "_cnt_en"},  32'(cnt_en_o[k]),  32'(e_en));
        check({tag, "_valid"},   32'(valid_o[k]),   32'(e_valid));
        check({tag, "_busy"},    32'(busy_o[k]),    32'(e_busy));
    endtask

    task automatic chk_res(input int k, input string tag, input logic [7:0] er, input bit eo);
        check({tag, "_result"}, 32'(result_o[k]), 32'(er));
        check({tag, "_ovf"},    32'(rovf_o[k]),   32'(eo));
    endtask

    // Driver: only instance k sees activity, the other stays quiet
    task automatic drive(input int k, input bit st, input bit ct, input bit p, input bit rd);
        start_v = '0; cont_v = '0; pulse_v = '0; ready_v = '0;
        start_v[k] = st; cont_v[k] = ct; pulse_v[k] = p; ready_v[k] = rd;
    endtask

    // One measurement. from_idle: issue start from IDLE first; otherwise the DUT is
    // expected to be in CLEAR already (previous handshake with continuous=1).
    task automatic meas(input int k, input bit from_idle, input bit cont,
                        input int ready_wait, input int pct);
        int         g;
        int         cnt;
        bit         p, e_en;
        logic [7:0] er;
        bit         eo;
        g   = (k == 0) ? G0 : G1;
        cnt = 0;
        if (from_idle) begin
            @(negedge clk); drive(k, 1'b1, rb(), rb(), rb()); #1;
            chk(k, "idle", 1'b0, 1'b0, 1'b0, 1'b0);
            chk_res(k, "idle_prev", last_res[k], last_ovf[k]);
        end
        @(negedge clk); drive(k, rb(), rb(), rb(), rb()); #1;
        chk(k, "clear", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_res(k, "clear_prev", last_res[k], last_ovf[k]);
        for (int i = 0; i < g; i++) begin
            @(negedge clk);
            p = ($urandom_range(0, 99) < pct);
            drive(k, rb(), rb(), p, rb()); #1;
`ifdef BCD_GATE_SATURATE_EN
            e_en = p && (cnt < MOD);
`else
            e_en = p;
`endif
            if (e_en) cnt++;
            chk(k, "gate", 1'b0, e_en, 1'b0, 1'b1);
        end
        @(negedge clk); drive(k, rb(), rb(), rb(), rb()); #1;
        chk(k, "settle", 1'b0, 1'b0, 1'b0, 1'b1);
        chk_res(k, "settle_prev", last_res[k], last_ovf[k]);
        eo = (cnt >= MOD);
        er = to_bcd(cnt % MOD);
`ifdef BCD_GATE_SATURATE_EN
        if (eo) er = 8'h99;
`endif
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk); drive(k, rb(), rb(), rb(), 1'b0); #1;
            chk(k, "hold", 1'b0, 1'b0, 1'b1, 1'b1);
            chk_res(k, "hold", er, eo);
        end
        @(negedge clk); drive(k, rb(), cont, rb(), 1'b1); #1;
        chk(k, "handshake", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_res(k, "handshake", er, eo);
        last_res[k] = er;
        last_ovf[k] = eo;
    endtask

    // Reset asserted n cycles into the gate of instance 0, then released
    task automatic abort_gate(input int n);
        @(negedge clk); drive(0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        chk(0, "abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        chk(0, "abort_clear", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); drive(0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
            chk(0, "abort_gate", 1'b0, 1'b1, 1'b0, 1'b1);
        end
        @(negedge clk); drive(0, 1'b0, 1'b1, 1'b1, 1'b1); rst = 1'b0; #1;
        chk(0, "abort_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_res(0, "abort_rst", 8'h00, 1'b0);
        last_res[0] = 8'h00; last_ovf[0] = 1'b0;
        last_res[1] = 8'h00; last_ovf[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1; #1;
        chk(0, "abort_release", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    // Stimulus sequence
    initial begin
        int pct_tab [6] = '{0, 35, 60, 100, 20, 80};
        bit cont, from_idle;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            last_res[k] = 8'h00;
            last_ovf[k] = 1'b0;
        end
        #2 rst = 1'b0;

        // Reset values, with every input of the instance pushing against them
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(k, 1'b1, 1'b1, 1'b1, 1'b1); #1;
            chk(k, "reset", 1'b1, 1'b0, 1'b0, 1'b0);
            chk_res(k, "reset", 8'h00, 1'b0);
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; #1;
        chk(0, "release", 1'b1, 1'b0, 1'b0, 1'b0);
        chk(1, "release", 1'b1, 1'b0, 1'b0, 1'b0);

        // Idle without start: nothing may happen
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drive(i % 2, 1'b0, rb(), rb(), rb()); #1;
            chk(i % 2, "quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Short gate: chained random measurements, a long stall, immediate ready
        from_idle = 1'b1;
        for (int m = 0; m < 8; m++) begin
            cont = (m == 7) ? 1'b0 : rb();
            if (m == 2) cont = 1'b1;
            meas(0, from_idle, cont, (m == 2) ? 10 : $urandom_range(0, 4), pct_tab[m % 6]);
            from_idle = !cont;
        end

        // Long gate: saturated input wraps the counter, then random densities
        meas(1, 1'b1, 1'b0, 0, 100);
        from_idle = 1'b1;
        for (int m = 0; m < 4; m++) begin
            cont = (m == 3) ? 1'b0 : rb();
            meas(1, from_idle, cont, $urandom_range(0, 3), $urandom_range(40, 100));
            from_idle = !cont;
        end

        // Abort mid-gate, then a fresh measurement on each instance
        abort_gate(5);
        meas(0, 1'b1, 1'b0, 1, 50);
        meas(1, 1'b1, 1'b0, 0, 95);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
